// File: rtl/spi_target_regs.sv
`default_nettype none
// ============================================================================
// Module   : spi_target_regs
// Purpose  : SPI mode-3 target with a small byte-addressed register file,
//            pins oversampled in clk. Optional macro: SPI_TARGET_WHOAMI_EN
//            (address 0x0F becomes a read-only WHOAMI_VAL constant).
// Revision : 1.0 - initial release
// ============================================================================
module spi_target_regs #(
    parameter int          NUM_REGS   = 16,
    parameter logic [7:0]  WHOAMI_VAL = 8'h33
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SCLK,
    input  logic        SS,
    input  logic        MOSI,
    output logic        MISO,
    output logic        MISO_oe,
    input  logic        loc_we,
    input  logic [5:0]  loc_addr,
    input  logic [7:0]  loc_wdata,
    output logic        wr_valid,
    output logic [5:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy
);

`ifdef SPI_TARGET_WHOAMI_EN
    localparam logic c_WHOAMI_EN = 1'b1;
`else
    localparam logic c_WHOAMI_EN = 1'b0;
`endif
    localparam logic [5:0] c_WHOAMI_ADDR = 6'h0F;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ADDR      = 2'd1,
        S_DATA      = 2'd2,
        S_WAIT_HIGH = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [2:0]  r_sclk_sync;
    logic [2:0]  r_ss_sync;
    logic [1:0]  r_mosi_sync;
    logic [2:0]  r_sync_vld;

    logic [2:0]  r_bit_cnt;
    logic [6:0]  r_rx;
    logic [7:0]  r_tx;
    logic        r_rw;
    logic        r_ms;
    logic [5:0]  r_addr;
    logic        r_miso;
    logic        r_wr_valid;
    logic [5:0]  r_wr_addr;
    logic [7:0]  r_wr_data;
    logic [7:0]  r_regs [NUM_REGS];

    logic        w_sclk_rise;
    logic        w_sclk_fall;
    logic        w_ss_fall;
    logic        w_ss_rise;
    logic        w_ss_low;
    logic        w_mosi;
    logic        w_in_frame;
    logic        w_byte_done;
    logic [7:0]  w_rx_next;
    logic [5:0]  w_addr_next;
    logic [5:0]  w_rd_addr;
    logic [7:0]  w_rd_data;
    logic        w_spi_we;
    logic        w_loc_we;

    function automatic logic addr_ok(input logic [5:0] a);
        return (int'(a) < NUM_REGS) && !(c_WHOAMI_EN && (a == c_WHOAMI_ADDR));
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= 3'b111;
            r_ss_sync   <= 3'b111;
            r_mosi_sync <= 2'b00;
            r_sync_vld  <= 3'b000;
        end else begin
            r_sclk_sync <= {r_sclk_sync[1:0], SCLK};
            r_ss_sync   <= {r_ss_sync[1:0], SS};
            r_mosi_sync <= {r_mosi_sync[0], MOSI};
            r_sync_vld  <= {r_sync_vld[1:0], 1'b1};
        end
    end

    // SS-fall is only trusted once the chain holds real pin samples, so an SS
    // already low at reset release lands in WAIT_HIGH instead of ADDR.
    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_sync[2];
    assign w_ss_fall   = r_sync_vld[2] & ~r_ss_sync[1] & r_ss_sync[2];
    assign w_ss_rise   = r_ss_sync[1] & ~r_ss_sync[2];
    assign w_ss_low    = ~r_ss_sync[1];
    assign w_mosi      = r_mosi_sync[1];

    assign w_in_frame  = ((r_state == S_ADDR) || (r_state == S_DATA)) && !w_ss_rise;
    assign w_byte_done = w_in_frame && w_sclk_rise && (r_bit_cnt == 3'd7);
    assign w_rx_next   = {r_rx, w_mosi};
    assign w_addr_next = r_ms ? (r_addr + 6'd1) : r_addr;
    assign w_rd_addr   = (r_state == S_ADDR) ? w_rx_next[5:0] : w_addr_next;
    assign w_spi_we    = w_byte_done && (r_state == S_DATA) && !r_rw && addr_ok(r_addr);
    assign w_loc_we    = loc_we && addr_ok(loc_addr);

    always_comb begin
        w_rd_data = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_rd_addr == 6'(i)) begin
                w_rd_data = r_regs[i];
            end
        end
        if (c_WHOAMI_EN && (w_rd_addr == c_WHOAMI_ADDR)) begin
            w_rd_data = WHOAMI_VAL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_ss_fall) begin
                    w_state_next = S_ADDR;
                end else if (w_ss_low) begin
                    w_state_next = S_WAIT_HIGH;
                end
            end
            S_ADDR: begin
                if (w_byte_done) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                w_state_next = S_DATA;
            end
            S_WAIT_HIGH: begin
                if (!w_ss_low) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        if (w_ss_rise) begin
            w_state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt  <= 3'd0;
            r_rx       <= 7'd0;
            r_tx       <= 8'h00;
            r_rw       <= 1'b0;
            r_ms       <= 1'b0;
            r_addr     <= 6'd0;
            r_miso     <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= 6'd0;
            r_wr_data  <= 8'h00;
        end else begin
            r_wr_valid <= 1'b0;
            if (!w_in_frame) begin
                r_bit_cnt <= 3'd0;
                r_miso    <= 1'b0;
            end else begin
                if (w_sclk_rise) begin
                    r_rx      <= w_rx_next[6:0];
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (w_byte_done) begin
                        if (r_state == S_ADDR) begin
                            r_rw   <= w_rx_next[7];
                            r_ms   <= w_rx_next[6];
                            r_addr <= w_rx_next[5:0];
                            if (w_rx_next[7]) begin
                                r_tx <= w_rd_data;
                            end
                        end else begin
                            r_addr <= w_addr_next;
                            if (r_rw) begin
                                r_tx <= w_rd_data;
                            end
                        end
                    end
                end
                if (w_sclk_fall) begin
                    if ((r_state == S_DATA) && r_rw) begin
                        r_miso <= r_tx[7];
                        r_tx   <= {r_tx[6:0], 1'b0};
                    end else begin
                        r_miso <= 1'b0;
                    end
                end
            end
            if (w_spi_we) begin
                r_wr_valid <= 1'b1;
                r_wr_addr  <= r_addr;
                r_wr_data  <= w_rx_next;
            end
        end
    end

    // SPI commit is assigned last so it wins a same-cycle local write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_loc_we && (loc_addr == 6'(i))) begin
                    r_regs[i] <= loc_wdata;
                end
                if (w_spi_we && (r_addr == 6'(i))) begin
                    r_regs[i] <= w_rx_next;
                end
            end
        end
    end

    assign MISO     = r_miso;
    assign MISO_oe  = w_ss_low;
    assign busy     = w_ss_low;
    assign wr_valid = r_wr_valid;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_spi_target_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_target_regs
// Purpose  : Scoreboard bench for spi_target_regs (honours SPI_TARGET_WHOAMI_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_target_regs;

    localparam int NUM_REGS = 48;
    localparam int HALF     = 60;
`ifdef SPI_TARGET_WHOAMI_EN
    localparam logic WHO_EN = 1'b1;
`else
    localparam logic WHO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        SCLK;
    logic        SS;
    logic        MOSI;
    logic        MISO;
    logic        MISO_oe;
    logic        loc_we;
    logic [5:0]  loc_addr;
    logic [7:0]  loc_wdata;
    logic        wr_valid;
    logic [5:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        busy;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  m [64];
    logic [7:0]  rq [$];
    logic [13:0] wq [$];
    logic [13:0] w_exp;
    logic [7:0]  rx;

    always #5 clk = ~clk;

    spi_target_regs #(.NUM_REGS(NUM_REGS), .WHOAMI_VAL(8'h33)) dut (
        .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .SS(SS), .MOSI(MOSI),
        .MISO(MISO), .MISO_oe(MISO_oe), .loc_we(loc_we), .loc_addr(loc_addr),
        .loc_wdata(loc_wdata), .wr_valid(wr_valid), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic mdl_wr_ok(input logic [5:0] a);
        return (int'(a) < NUM_REGS) && !(WHO_EN && (a == 6'h0F));
    endfunction

    function automatic logic [7:0] mdl_read(input logic [5:0] a);
        if (WHO_EN && (a == 6'h0F)) return 8'h33;
        if (int'(a) < NUM_REGS) return m[a];
        return 8'h00;
    endfunction

    task automatic xfer(input logic [7:0] b, output logic [7:0] r);
        for (int i = 7; i >= 0; i--) begin
            SCLK = 1'b0;
            MOSI = b[i];
            #HALF;
            r[i] = MISO;
            SCLK = 1'b1;
            #HALF;
        end
    endtask

    task automatic begin_txn();
        SS = 1'b0;
        #HALF;
        check_val("busy_on", 32'(busy), 32'd1);
        check_val("oe_on", 32'(MISO_oe), 32'd1);
    endtask

    task automatic end_txn();
        #HALF;
        SS = 1'b1;
        #(2 * HALF);
        check_val("busy_off", 32'(busy), 32'd0);
    endtask

    task automatic loc_write(input logic [5:0] a, input logic [7:0] d);
        loc_addr  = a;
        loc_wdata = d;
        loc_we    = 1'b1;
        #10;
        loc_we    = 1'b0;
        if (mdl_wr_ok(a)) m[a] = d;
    endtask

    task automatic spi_txn(input logic [7:0] hdr, input int nd,
                           input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        logic [7:0] d [3];
        logic [5:0] a;
        logic [7:0] r;
        d[0] = d0; d[1] = d1; d[2] = d2;
        a = hdr[5:0];
        begin_txn();
        rq.push_back(8'h00);
        xfer(hdr, r);
        check_val("miso_hdr", 32'(r), 32'(rq.pop_front()));
        for (int i = 0; i < nd; i++) begin
            if (hdr[7]) begin
                rq.push_back(mdl_read(a));
            end else begin
                rq.push_back(8'h00);
                if (mdl_wr_ok(a)) begin
                    wq.push_back({a, d[i]});
                    m[a] = d[i];
                end
            end
            if (hdr[6]) a = a + 6'd1;
            xfer(d[i], r);
            check_val("miso_data", 32'(r), 32'(rq.pop_front()));
        end
        end_txn();
    endtask

    always @(negedge clk) begin
        if (rst_n && wr_valid) begin
            if (wq.size() == 0) begin
                check_val("wr_unexpected", 32'(wr_valid), 32'd0);
            end else begin
                w_exp = wq.pop_front();
                check_val("wr_addr", 32'(wr_addr), 32'(w_exp[13:8]));
                check_val("wr_data", 32'(wr_data), 32'(w_exp[7:0]));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: timeout reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) m[i] = 8'h00;
        rst_n = 1'b0; SS = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
        loc_we = 1'b0; loc_addr = 6'd0; loc_wdata = 8'h00;
        #30;
        check_val("rst_miso", 32'(MISO), 32'd0);
        check_val("rst_oe", 32'(MISO_oe), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_wr_valid", 32'(wr_valid), 32'd0);
        check_val("rst_wr_addr", 32'(wr_addr), 32'd0);
        check_val("rst_wr_data", 32'(wr_data), 32'd0);
        rst_n = 1'b1;
        #100;

        spi_txn(8'h05, 1, 8'hA5, 8'h00, 8'h00);
        spi_txn(8'h85, 1, 8'h00, 8'h00, 8'h00);

        loc_write(6'd2, 8'h11);
        loc_write(6'd3, 8'h22);
        spi_txn(8'hC2, 2, 8'h00, 8'h00, 8'h00);
        spi_txn(8'h82, 2, 8'h00, 8'h00, 8'h00);

        spi_txn(8'h7F, 2, 8'hAA, 8'hBB, 8'h00);
        spi_txn(8'h80, 1, 8'h00, 8'h00, 8'h00);
        spi_txn(8'hBF, 1, 8'h00, 8'h00, 8'h00);
        spi_txn(8'h6E, 3, 8'h5C, 8'h6D, 8'h7E);
        spi_txn(8'hEE, 3, 8'h00, 8'h00, 8'h00);

        // Abort: header plus a partial data byte must not commit.
        begin_txn();
        xfer(8'h04, rx);
        check_val("abort_hdr", 32'(rx), 32'd0);
        for (int i = 0; i < 5; i++) begin
            SCLK = 1'b0; MOSI = 1'b1; #HALF;
            SCLK = 1'b1; #HALF;
        end
        end_txn();
        spi_txn(8'h84, 1, 8'h00, 8'h00, 8'h00);
        spi_txn(8'h04, 1, 8'h77, 8'h00, 8'h00);
        spi_txn(8'h84, 1, 8'h00, 8'h00, 8'h00);

        // Local write to a register whose byte is already in the TX shifter.
        loc_write(6'd7, 8'h5A);
        loc_write(6'h30, 8'h99);
        begin_txn();
        xfer(8'h87, rx);
        check_val("inflight_hdr", 32'(rx), 32'd0);
        rq.push_back(mdl_read(6'd7));
        loc_write(6'd7, 8'hC3);
        xfer(8'h00, rx);
        check_val("inflight_data", 32'(rx), 32'(rq.pop_front()));
        end_txn();
        spi_txn(8'h87, 1, 8'h00, 8'h00, 8'h00);
        spi_txn(8'hB0, 1, 8'h00, 8'h00, 8'h00);

        spi_txn(8'h8F, 1, 8'h00, 8'h00, 8'h00);
        spi_txn(8'h0F, 1, 8'h55, 8'h00, 8'h00);
        spi_txn(8'h8F, 1, 8'h00, 8'h00, 8'h00);

        // Reset in the middle of a data byte with SS held low.
        begin_txn();
        xfer(8'h06, rx);
        for (int i = 0; i < 3; i++) begin
            SCLK = 1'b0; MOSI = 1'b1; #HALF;
            SCLK = 1'b1; #HALF;
        end
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_miso", 32'(MISO), 32'd0);
        check_val("mid_rst_oe", 32'(MISO_oe), 32'd0);
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        check_val("mid_rst_wr_valid", 32'(wr_valid), 32'd0);
        check_val("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
        check_val("mid_rst_wr_data", 32'(wr_data), 32'd0);
        for (int i = 0; i < 64; i++) m[i] = 8'h00;
        #29;
        rst_n = 1'b1;
        #HALF;
        check_val("wait_high_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 13; i++) begin
            SCLK = 1'b0; MOSI = 1'b1; #HALF;
            SCLK = 1'b1; #HALF;
        end
        end_txn();
        spi_txn(8'h01, 1, 8'h3C, 8'h00, 8'h00);
        spi_txn(8'h81, 1, 8'h00, 8'h00, 8'h00);
        spi_txn(8'h85, 1, 8'h00, 8'h00, 8'h00);

        #200;
        check_val("wq_drained", 32'(wq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_target_regs.md
# spi_target_regs

SPI target (responder) with a small byte-addressed register file. It answers the single-byte-address SPI framing used by our sensor drivers: first byte is {RW, MS, addr[5:0]}, then data bytes. Used for loopback bring-up of the SPI master and as a LIS3DH-style register model in system simulation. All SPI pins are oversampled in the `clk` domain; there is no second clock.

## Interface

Parameters:
- `NUM_REGS`, 16: implemented registers, addresses 0..NUM_REGS-1 (max 64).
- `WHOAMI_VAL`, 8'h33: constant returned at address 0x0F when the WHOAMI feature is compiled in.

Ports:
- `clk`  in  1  system clock. All logic on posedge.
- `rst_n`  in  1  asynchronous active-low reset.
- `SCLK`  in  1  SPI clock from master. CPOL=1: idle high.
- `SS`  in  1  slave select, active low.
- `MOSI`  in  1  serial data in, MSB first.
- `MISO`  out  1  serial data out, MSB first.
- `MISO_oe`  out  1  MISO drive enable. High while the synchronized SS is low.
- `loc_we`  in  1  local write strobe, updates a register from fabric.
- `loc_addr`  in  6  local write address.
- `loc_wdata`  in  8  local write data.
- `wr_valid`  out  1  one-cycle pulse when an SPI write commits.
- `wr_addr`  out  6  address of the committed write.
- `wr_data`  out  8  data of the committed write.
- `busy`  out  1  high while a transaction is framed (synchronized SS low).

## Operation

- SCLK, SS and MOSI each pass through a 2-flop synchronizer. Edge detection compares the 2nd flop against a 3rd.
- SPI mode 3. MOSI is sampled on the SCLK rising edge. MISO is updated on the SCLK falling edge.
- FSM states:
  - IDLE: wait for an SS falling edge, then go to ADDR with bit_cnt=0.
  - ADDR: shift 8 MOSI bits. On the 8th rising edge, latch RW=bit7, MS=bit6, addr=bits[5:0], then go to DATA. If RW=1, load the TX shifter with the read value of addr.
  - DATA: shift 8 bits per byte. On each 8th rising edge:
    - If RW=0: commit the write.
    - If RW=1: reload the TX shifter with the next address.
    - If MS=1: addr increments modulo 64 (0x3F→0x00). If MS=0: addr holds.
  - WAIT_HIGH: entered from reset when the synchronized SS is low. Ignore everything until SS is seen high, then go to IDLE.
- SS rising edge in any state: return to IDLE. A partial byte is discarded: no commit, no wr_valid. bit_cnt clears.
- Read value:
  - reg[addr] if addr < NUM_REGS.
  - 8'h00 otherwise.
- Write commit:
  - If addr < NUM_REGS, reg[addr] ← byte, and wr_valid pulses with wr_addr/wr_data.
  - Out-of-range writes are dropped with no pulse.
- MISO is 0 during ADDR and in IDLE. In DATA with RW=1 it is the TX shifter MSB. With RW=0 it is 0.
- Local port: loc_we writes reg[loc_addr] when loc_addr < NUM_REGS.
  - If an SPI commit hits the same address in the same cycle, the SPI write wins.
  - A local write to a register already loaded into the TX shifter does not alter the byte in flight.
- Reset values:
  - All registers 8'h00.
  - MISO=0, MISO_oe=0, wr_valid=0, wr_addr=0, wr_data=0, busy=0.
  - Synchronizer flops reset to 1 for SCLK/SS and 0 for MOSI.
  - FSM resets to IDLE. It then moves to WAIT_HIGH if the synchronized SS is low.

## Timing

- SCLK high and low phases must each be ≥4 clk cycles. SS setup to the first SCLK falling edge must be ≥4 clk.
- Input latency: a pin edge is acted on 3 clk after it occurs (2 synchronizer stages + edge detect).
- MISO changes 3 clk after the SCLK falling edge at the pin. It is therefore stable before the next rising edge when the half period is ≥4 clk.
- wr_valid, the register update and the wr_addr/wr_data update all occur in the same clk edge, 3 clk after the 8th SCLK rising edge of the data byte.
- busy and MISO_oe follow SS with 2-clk latency.

## Configuration

- `SPI_TARGET_WHOAMI_EN` defined:
  - Address 0x0F reads WHOAMI_VAL.
  - SPI and local writes to 0x0F are dropped, with no wr_valid.
  - This applies even when NUM_REGS ≤ 15.
- Undefined: 0x0F is an ordinary register, or out-of-range if NUM_REGS ≤ 15.

## Test plan

- Single write: SS low, send 0x05, 0xA5, SS high → reg[5]=0xA5; one wr_valid pulse with wr_addr=5, wr_data=0xA5.
- Burst read with MS: preload reg[2]=0x11, reg[3]=0x22; send 0xC2, 0x00, 0x00 → MISO bytes 0x00, 0x11, 0x22. Repeat with 0x82 → 0x00, 0x11, 0x11.
- Wrap: write burst 0x7F, 0xAA, 0xBB with NUM_REGS=64 → reg[63]=0xAA, reg[0]=0xBB.
- Abort: send 0x04, then 5 bits of 0xFF, then SS high → no wr_valid and reg[4] unchanged. The next transaction decodes normally.
- Reset mid-transaction: assert rst_n low during a data byte with SS held low → all outputs at reset values, and the remaining SCLK edges are ignored until SS goes high. A following write of 0x01, 0x3C succeeds.
- WHOAMI (macro defined): send 0x8F, 0x00 → MISO byte 2 = 0x33. Write 0x0F, 0x55 → no wr_valid, and a read still returns 0x33.
